// File: rtl/ps2_host_tx_checker_if.sv
// Bus bundle for the PS/2 host-to-device frame checker: raw PS/2 lines plus
// the show-ahead FIFO read side and status flags.
interface ps2_host_tx_checker_if #(
  parameter int DATA_BITS = 8,
  parameter int REQ_CNT_W = 16
);
  logic                 ps2c;
  logic                 ps2d;
  logic                 rd_en;
  logic                 ovf_clr;
  logic [DATA_BITS-1:0] rd_data;
  logic [3:0]           rd_err;
  logic [REQ_CNT_W-1:0] rd_req_time;
  logic                 empty;
  logic                 full;
  logic                 overflow;
  logic                 busy;

  // master: whoever drives the lines and reads entries; slave: the checker
  modport master (
    output ps2c, ps2d, rd_en, ovf_clr,
    input  rd_data, rd_err, rd_req_time, empty, full, overflow, busy
  );

  modport slave (
    input  ps2c, ps2d, rd_en, ovf_clr,
    output rd_data, rd_err, rd_req_time, empty, full, overflow, busy
  );
endinterface

// File: rtl/ps2_host_tx_checker.sv
// Passive PS/2 host-to-device frame monitor: tracks each frame phase, measures
// the request time and queues every finished or aborted frame with error flags.
module ps2_host_tx_checker #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 20000,
  parameter int REQ_CNT_W   = 16
) (
  input  logic clk,
  input  logic reset,
  ps2_host_tx_checker_if.slave bus
);

  localparam int BC_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW   = DATA_BITS + 4 + REQ_CNT_W;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_START, S_DATA, S_PAR, S_STOP, S_ACK
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           c_pipe_q, c_pipe_d;
  logic [2:0]           d_pipe_q, d_pipe_d;
  logic [REQ_CNT_W-1:0] req_cnt_q, req_cnt_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_err_q, par_err_d;
  logic                 stop_err_q, stop_err_d;
  logic [TO_W-1:0]      idle_cnt_q, idle_cnt_d;

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          cnt_q, cnt_d;
  logic                 overflow_q, overflow_d;
  logic [EW-1:0]        mem_q [FIFO_DEPTH];

  logic c_rise, c_fall, d_rise, d_fall, d_lvl, any_edge, timeout;
  logic push, push_ack_err, push_to;
  logic fifo_empty, fifo_full, do_push, do_pop, drop;
  logic [EW-1:0] entry_in, head;

  // Bit 0/1 form the synchronizer, bit 2 holds the previous synchronized level
  assign c_rise   =  c_pipe_q[1] & ~c_pipe_q[2];
  assign c_fall   = ~c_pipe_q[1] &  c_pipe_q[2];
  assign d_rise   =  d_pipe_q[1] & ~d_pipe_q[2];
  assign d_fall   = ~d_pipe_q[1] &  d_pipe_q[2];
  assign d_lvl    =  d_pipe_q[1];
  assign any_edge = c_rise | c_fall | d_rise | d_fall;

  always_comb begin
    state_d      = state_q;
    c_pipe_d     = {c_pipe_q[1:0], bus.ps2c};
    d_pipe_d     = {d_pipe_q[1:0], bus.ps2d};
    req_cnt_d    = req_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    data_d       = data_q;
    par_err_d    = par_err_q;
    stop_err_d   = stop_err_q;
    push         = 1'b0;
    push_ack_err = 1'b0;
    push_to      = 1'b0;

    if (state_q == S_IDLE || any_edge) idle_cnt_d = '0;
    else                               idle_cnt_d = idle_cnt_q + 1'b1;

    timeout = (state_q != S_IDLE) && !any_edge &&
              (idle_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    unique case (state_q)
      S_IDLE: begin
        if (c_fall) begin
          state_d    = S_REQ;
          req_cnt_d  = '0;
          data_d     = '0;
          par_err_d  = 1'b0;
          stop_err_d = 1'b0;
        end
      end
      S_REQ: begin
        if (d_fall) state_d = S_START;
        else if (req_cnt_q != '1) req_cnt_d = req_cnt_q + 1'b1;
      end
      S_START: begin
        if (c_rise) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (c_rise) begin
          data_d[bit_cnt_q] = d_lvl;
          bit_cnt_d         = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BC_W'(DATA_BITS - 1))
            state_d = (PARITY_MODE == 0) ? S_STOP : S_PAR;
        end
      end
      S_PAR: begin
        if (c_rise) begin
          par_err_d = (PARITY_MODE == 1) ? ~(^{d_lvl, data_q}) : (^{d_lvl, data_q});
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (c_rise) begin
          stop_err_d = ~d_lvl;
          state_d    = S_ACK;
        end
      end
      S_ACK: begin
        if (c_fall) begin
          push         = 1'b1;
          push_ack_err = d_lvl;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An abort keeps whatever data and earlier flags were gathered so far
    if (timeout) begin
      push         = 1'b1;
      push_to      = 1'b1;
      push_ack_err = 1'b0;
      state_d      = S_IDLE;
    end
  end

  assign entry_in = {data_q, push_to, push_ack_err, stop_err_q, par_err_q, req_cnt_q};

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign do_pop     = bus.rd_en & ~fifo_empty;
  assign do_push    = push & (~fifo_full | do_pop);
  assign drop       = push & fifo_full & ~do_pop;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    overflow_d = overflow_q;
    if (drop)             overflow_d = 1'b1;
    else if (bus.ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      c_pipe_q   <= '1;
      d_pipe_q   <= '1;
      req_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      idle_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      c_pipe_q   <= c_pipe_d;
      d_pipe_q   <= d_pipe_d;
      req_cnt_q  <= req_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
      idle_cnt_q <= idle_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_in;
  end

  // Storage is not reset, so the head is masked to zero while the FIFO is empty
  assign head            = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign bus.rd_data     = head[EW-1 -: DATA_BITS];
  assign bus.rd_err      = head[REQ_CNT_W +: 4];
  assign bus.rd_req_time = head[REQ_CNT_W-1:0];
  assign bus.empty       = fifo_empty;
  assign bus.full        = fifo_full;
  assign bus.overflow    = overflow_q;
  assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_host_tx_checker.sv
// Scoreboard bench for ps2_host_tx_checker: three instances (odd parity with
// short timeout, even parity, 9-bit no parity) each driven by its own PS/2 lines.
module tb_ps2_host_tx_checker;

  localparam int H = 5;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  err;
    logic [15:0] rt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_drv     [3];
  logic ps2c_drv    [3];
  logic ps2d_drv    [3];
  logic rd_en_drv   [3];
  logic ovf_clr_drv [3];

  logic [15:0] obs_data  [3];
  logic [3:0]  obs_err   [3];
  logic [15:0] obs_rt    [3];
  logic        obs_empty [3];
  logic        obs_full  [3];
  logic        obs_ovf   [3];
  logic        obs_busy  [3];

  int checks   = 0;
  int failures = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  ps2_host_tx_checker_if #(.DATA_BITS(8), .REQ_CNT_W(16)) if_a ();
  ps2_host_tx_checker_if #(.DATA_BITS(8), .REQ_CNT_W(16)) if_b ();
  ps2_host_tx_checker_if #(.DATA_BITS(9), .REQ_CNT_W(16)) if_c ();

  assign if_a.ps2c = ps2c_drv[0];  assign if_a.ps2d = ps2d_drv[0];
  assign if_a.rd_en = rd_en_drv[0]; assign if_a.ovf_clr = ovf_clr_drv[0];
  assign if_b.ps2c = ps2c_drv[1];  assign if_b.ps2d = ps2d_drv[1];
  assign if_b.rd_en = rd_en_drv[1]; assign if_b.ovf_clr = ovf_clr_drv[1];
  assign if_c.ps2c = ps2c_drv[2];  assign if_c.ps2d = ps2d_drv[2];
  assign if_c.rd_en = rd_en_drv[2]; assign if_c.ovf_clr = ovf_clr_drv[2];

  assign obs_data[0] = 16'(if_a.rd_data); assign obs_err[0] = if_a.rd_err;
  assign obs_rt[0] = if_a.rd_req_time;    assign obs_empty[0] = if_a.empty;
  assign obs_full[0] = if_a.full;         assign obs_ovf[0] = if_a.overflow;
  assign obs_busy[0] = if_a.busy;
  assign obs_data[1] = 16'(if_b.rd_data); assign obs_err[1] = if_b.rd_err;
  assign obs_rt[1] = if_b.rd_req_time;    assign obs_empty[1] = if_b.empty;
  assign obs_full[1] = if_b.full;         assign obs_ovf[1] = if_b.overflow;
  assign obs_busy[1] = if_b.busy;
  assign obs_data[2] = 16'(if_c.rd_data); assign obs_err[2] = if_c.rd_err;
  assign obs_rt[2] = if_c.rd_req_time;    assign obs_empty[2] = if_c.empty;
  assign obs_full[2] = if_c.full;         assign obs_ovf[2] = if_c.overflow;
  assign obs_busy[2] = if_c.busy;

  ps2_host_tx_checker #(.DATA_BITS(8), .PARITY_MODE(1), .FIFO_DEPTH(4),
                        .TIMEOUT_CYC(1000), .REQ_CNT_W(16))
    u_odd (.clk(clk), .reset(rst_drv[0]), .bus(if_a));

  ps2_host_tx_checker #(.DATA_BITS(8), .PARITY_MODE(2), .FIFO_DEPTH(4),
                        .TIMEOUT_CYC(20000), .REQ_CNT_W(16))
    u_even (.clk(clk), .reset(rst_drv[1]), .bus(if_b));

  ps2_host_tx_checker #(.DATA_BITS(9), .PARITY_MODE(0), .FIFO_DEPTH(4),
                        .TIMEOUT_CYC(1000), .REQ_CNT_W(16))
    u_nine (.clk(clk), .reset(rst_drv[2]), .bus(if_c));

  // Every comparison in the bench funnels through here
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_entry(input int u, input logic [15:0] data,
                              input logic [3:0] err, input logic [15:0] rt);
    exp_t e;
    e.data = data; e.err = err; e.rt = rt;
    case (u)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic compare_head(input int u);
    exp_t e;
    bit   got;
    int   diff;
    logic [15:0] rt_adj;
    got = 1'b0;
    e   = '0;
    case (u)
      0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
    endcase
    if (!got) begin
      checkOutput($sformatf("u%0d scoreboard_has_entry", u), 0, 1);
      return;
    end
    checkOutput($sformatf("u%0d rd_data", u), 32'(obs_data[u]), 32'(e.data));
    checkOutput($sformatf("u%0d rd_err", u), 32'(obs_err[u]), 32'(e.err));
    diff   = int'(obs_rt[u]) - int'(e.rt);
    rt_adj = (diff >= -3 && diff <= 3) ? e.rt : obs_rt[u];
    checkOutput($sformatf("u%0d rd_req_time", u), 32'(rt_adj), 32'(e.rt));
  endtask

  task automatic drain_one(input int u);
    int n;
    n = 0;
    while (obs_empty[u] && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("u%0d entry_visible(empty)", u), 32'(obs_empty[u]), 0);
    compare_head(u);
    rd_en_drv[u] = 1'b1;
    @(negedge clk);
    rd_en_drv[u] = 1'b0;
  endtask

  task automatic send_bit(input int u, input logic b);
    wait_cycles(H);
    ps2c_drv[u] = 1'b0;
    ps2d_drv[u] = b;
    wait_cycles(H);
    ps2c_drv[u] = 1'b1;
  endtask

  // One host frame; abort_after>=0 stops clocking after that many data bits
  task automatic applyStimulus(input int u, input logic [15:0] data, input int nbits,
                               input bit has_par, input bit par, input bit stop,
                               input bit ack, input int req, input int abort_after,
                               input bit pop_at_push);
    @(negedge clk);
    ps2c_drv[u] = 1'b0;
    wait_cycles(req);
    ps2d_drv[u] = 1'b0;
    wait_cycles(H);
    ps2c_drv[u] = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      if (abort_after >= 0 && i == abort_after) return;
      send_bit(u, data[i]);
    end
    if (has_par) send_bit(u, par);
    send_bit(u, stop);
    wait_cycles(H);
    ps2d_drv[u] = ack;
    wait_cycles(H);
    ps2c_drv[u] = 1'b0;
    if (pop_at_push) begin
      wait_cycles(2);
      rd_en_drv[u] = 1'b1;
      wait_cycles(1);
      rd_en_drv[u] = 1'b0;
      wait_cycles(H - 3);
    end else begin
      wait_cycles(H);
    end
    ps2c_drv[u] = 1'b1;
    ps2d_drv[u] = 1'b1;
    wait_cycles(H);
  endtask

  task automatic check_reset_state(input int u);
    checkOutput($sformatf("u%0d rst empty", u), 32'(obs_empty[u]), 1);
    checkOutput($sformatf("u%0d rst full", u), 32'(obs_full[u]), 0);
    checkOutput($sformatf("u%0d rst overflow", u), 32'(obs_ovf[u]), 0);
    checkOutput($sformatf("u%0d rst busy", u), 32'(obs_busy[u]), 0);
    checkOutput($sformatf("u%0d rst rd_data", u), 32'(obs_data[u]), 0);
    checkOutput($sformatf("u%0d rst rd_err", u), 32'(obs_err[u]), 0);
    checkOutput($sformatf("u%0d rst rd_req_time", u), 32'(obs_rt[u]), 0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] fd;
    for (int u = 0; u < 3; u++) begin
      rst_drv[u] = 1'b0; ps2c_drv[u] = 1'b1; ps2d_drv[u] = 1'b1;
      rd_en_drv[u] = 1'b0; ovf_clr_drv[u] = 1'b0;
    end
    wait_cycles(3);
    for (int u = 0; u < 3; u++) check_reset_state(u);
    for (int u = 0; u < 3; u++) rst_drv[u] = 1'b1;
    wait_cycles(3);

    // Clean frame with a measured 200-cycle request
    applyStimulus(0, 16'h41, 8, 1, 1, 1, 0, 200, -1, 0);
    expect_entry(0, 16'h41, 4'b0000, 16'd200);
    drain_one(0);
    checkOutput("u0 busy after frame", 32'(obs_busy[0]), 0);
    checkOutput("u0 empty after pop", 32'(obs_empty[0]), 1);

    // Parity: wrong for odd, right for even
    applyStimulus(0, 16'h41, 8, 1, 0, 1, 0, 40, -1, 0);
    expect_entry(0, 16'h41, 4'b0001, 16'd40);
    drain_one(0);
    applyStimulus(1, 16'h41, 8, 1, 0, 1, 0, 40, -1, 0);
    expect_entry(1, 16'h41, 4'b0000, 16'd40);
    drain_one(1);

    // Bad stop bit and missing ack
    applyStimulus(0, 16'h5A, 8, 1, 1, 0, 1, 30, -1, 0);
    expect_entry(0, 16'h5A, 4'b0110, 16'd30);
    drain_one(0);

    // Clocking stops after bits 1,0,1
    applyStimulus(0, 16'h05, 8, 1, 0, 1, 0, 30, 3, 0);
    checkOutput("u0 busy after stall", 32'(obs_busy[0]), 1);
    expect_entry(0, 16'h05, 4'b1000, 16'd30);
    wait_cycles(990);
    checkOutput("u0 busy before timeout", 32'(obs_busy[0]), 1);
    checkOutput("u0 empty before timeout", 32'(obs_empty[0]), 1);
    wait_cycles(30);
    checkOutput("u0 busy after timeout", 32'(obs_busy[0]), 0);
    drain_one(0);

    // Five frames into a four-deep FIFO with no reads
    for (int k = 1; k <= 5; k++) begin
      fd = 16'(8'h10 + 8'(k));
      applyStimulus(0, fd, 8, 1, ~(^fd[7:0]), 1, 0, 20, -1, 0);
      if (k <= 4) expect_entry(0, fd, 4'b0000, 16'd20);
    end
    checkOutput("u0 full after 5", 32'(obs_full[0]), 1);
    checkOutput("u0 overflow after 5", 32'(obs_ovf[0]), 1);
    compare_head(0);
    fd = 16'h16;
    applyStimulus(0, fd, 8, 1, ~(^fd[7:0]), 1, 0, 20, -1, 1);
    expect_entry(0, fd, 4'b0000, 16'd20);
    checkOutput("u0 full after push+pop", 32'(obs_full[0]), 1);
    ovf_clr_drv[0] = 1'b1;
    wait_cycles(1);
    ovf_clr_drv[0] = 1'b0;
    checkOutput("u0 overflow cleared", 32'(obs_ovf[0]), 0);
    for (int k = 0; k < 4; k++) drain_one(0);
    checkOutput("u0 empty after drain", 32'(obs_empty[0]), 1);

    // Nine-bit frame without parity, then an asynchronous reset mid-data
    applyStimulus(2, 16'h1A5, 9, 0, 0, 1, 0, 25, -1, 0);
    expect_entry(2, 16'h1A5, 4'b0000, 16'd25);
    compare_head(2);
    applyStimulus(2, 16'h0FF, 9, 0, 0, 1, 0, 25, 4, 0);
    checkOutput("u2 busy mid-data", 32'(obs_busy[2]), 1);
    rst_drv[2] = 1'b0;
    #1;
    checkOutput("u2 busy in reset", 32'(obs_busy[2]), 0);
    checkOutput("u2 empty in reset", 32'(obs_empty[2]), 1);
    checkOutput("u2 rd_data in reset", 32'(obs_data[2]), 0);
    @(negedge clk);
    ps2c_drv[2] = 1'b1;
    ps2d_drv[2] = 1'b1;
    rst_drv[2]  = 1'b1;
    wait_cycles(3);
    applyStimulus(2, 16'h0F3, 9, 0, 0, 1, 0, 25, -1, 0);
    expect_entry(2, 16'h0F3, 4'b0000, 16'd25);
    drain_one(2);
    checkOutput("u2 empty at end", 32'(obs_empty[2]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx_checker.md
Name: ps2_host_tx_checker

Overview:
Synthesizable, passive monitor for PS/2 host-to-device frames on a shared ps2c/ps2d pair. It never drives the bus. It synchronizes both lines, tracks request-to-send, start, data, parity, stop and ack phases, and measures the request duration. Each completed or aborted frame goes into a show-ahead FIFO with per-frame error flags, so on-chip logic or a debug UART can read them. It is the in-hardware successor to the simulation-only host-send monitor, with configurable width, parity mode, timeout and buffering.

Parameters:
DATA_BITS, 8, data bits per frame, sent LSB first (1..16).
PARITY_MODE, 1, 0 = no parity bit, 1 = odd, 2 = even.
FIFO_DEPTH, 4, number of FIFO entries (power of 2, ≥2).
TIMEOUT_CYC, 20000, clk cycles with no ps2c/ps2d edge before a non-IDLE frame aborts.
REQ_CNT_W, 16, width of the request-time counter (saturating).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
ps2c  in  1  raw PS/2 clock line (asynchronous)
ps2d  in  1  raw PS/2 data line (asynchronous)
rd_en  in  1  pop the FIFO head; ignored when empty
ovf_clr  in  1  clears the overflow flag
rd_data  out  DATA_BITS  head entry data
rd_err  out  4  head entry flags: [0] parity, [1] stop, [2] ack, [3] timeout
rd_req_time  out  REQ_CNT_W  head entry request duration, in clk cycles
empty  out  1  FIFO empty
full  out  1  FIFO full
overflow  out  1  sticky: a frame was dropped
busy  out  1  FSM is not in IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; FIFO pointers are cleared.
  - empty=1, full=0, overflow=0, busy=0.
  - rd_data, rd_err and rd_req_time = 0.
  - Synchronizer flops are preset to 1 (idle bus).
- Synchronization:
  - Each line passes through a 2-flop synchronizer plus a history flop.
  - rise/fall strobes are single-cycle.
  - The FSM acts on a strobe in the cycle it is high.
  - An entry is visible (empty=0) at most 4 clk cycles after the raw ack falling edge.
- FSM states and transitions:
  - IDLE: on ps2c fall → REQ; clear req_cnt and shift register.
  - REQ: req_cnt increments every cycle, saturating at all-ones. On ps2d fall → START; latch req_cnt.
  - START: on ps2c rise (host releases clock) → DATA; clear bit_cnt.
  - DATA: on each ps2c rise, sample ps2d into bit[bit_cnt], bit_cnt+1. After the DATA_BITS-th sample → PAR, or → STOP when PARITY_MODE=0.
  - PAR: on ps2c rise, sample the parity bit. Parity error if XOR of {parity,data} is ≠1 (odd mode) or ≠0 (even mode).
  - STOP: on ps2c rise, sample the stop bit; stop error if it is 0 → ACK.
  - ACK: on ps2c fall, sample ps2d; ack error if it is 1. Push the entry → IDLE.
  - ps2d edges outside REQ are ignored.
- Timeout:
  - The idle counter clears on any ps2c/ps2d edge and in IDLE.
  - In any other state, reaching TIMEOUT_CYC pushes an entry → IDLE. That entry has flag[3]=1, data bits received so far (unreceived bits 0), earlier-phase flags as accumulated, and ack error 0.
  - A timeout in REQ pushes req_time = saturated/current count.
- FIFO:
  - Show-ahead: head outputs are valid whenever empty=0; rd_en with empty=0 advances the head at the next clk edge.
  - Push while full with no pop in the same cycle: the entry is dropped and overflow=1.
  - Push and pop in the same cycle while full: both succeed; full stays 1.
  - Push and pop in the same cycle while empty: the push is stored; empty=0 next cycle.
- overflow: clears on ovf_clr=1 unless a drop occurs in the same cycle (set wins).
- busy = (state != IDLE).

Test Plan:
1. Defaults. Host frame 0x41 with parity 1, stop 1, ack 0; ps2c held low 200 cycles before ps2d falls → one entry: rd_data=0x41, rd_err=0000, rd_req_time=200 (±3), busy=0 afterwards.
2. Frame 0x41 with parity 0 → rd_err=0001. Repeat with PARITY_MODE=2 and parity 0 → rd_err=0000.
3. Frame 0x5A with ack bit driven 1 and stop bit 0 → rd_err=0110.
4. Clocking stops after 3 data bits 1,0,1 with TIMEOUT_CYC=1000 → after 1000 cycles, entry rd_data=0x05, rd_err=1000; FSM in IDLE.
5. FIFO_DEPTH=4: send 5 valid frames with no reads → full=1, overflow=1, entries hold frames 1-4. Pop on the same cycle as the 6th push → 6th frame stored; pulse ovf_clr → overflow=0.
6. DATA_BITS=9, PARITY_MODE=0: frame 0x1A5 → rd_data=0x1A5, rd_err=0000. Separately, assert reset low mid-DATA → busy=0, empty=1 immediately; next frame is captured correctly.
